// File: rtl/sklansky_pkg.sv
// Shared definitions for the pipelined Sklansky adder/subtractor.
//   OP_ADD / OP_SUB   : operation select encodings
//   pg_t              : (generate, propagate) pair carried through the prefix tree
//   sklansky_partner  : lower-neighbour index a bit combines with at a given tree level
package sklansky_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // At level lvl, bit idx (with bit lvl of idx set) combines with the last bit of the
    // preceding 2^lvl block, i.e. idx with its low lvl bits cleared, minus one.
    function automatic int unsigned sklansky_partner(int unsigned idx, int unsigned lvl);
        return ((idx >> lvl) << lvl) - 1;
    endfunction

endpackage

// File: rtl/sklansky_black_cell.sv
// Combinational prefix combiner (G,P) o (G',P').
//   hi_i  : (g,p) of the more significant span
//   lo_i  : (g,p) of the adjacent less significant span
//   res_o : (g,p) of the merged span
module sklansky_black_cell
    import sklansky_pkg::*;
(
    input  pg_t hi_i,
    input  pg_t lo_i,
    output pg_t res_o
);

    assign res_o.g = hi_i.g | (hi_i.p & lo_i.g);
    assign res_o.p = hi_i.p & lo_i.p;

endmodule

// File: rtl/sklansky_addsub_pipe.sv
// Two-stage pipelined Sklansky prefix adder/subtractor with valid/ready on both sides.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (op, A, B, cin sampled on acceptance)
//   op                   : 0 = A + B + cin, 1 = A - B - cin
//   out_valid / out_ready: result handshake; Sum, cout, ovf held stable while stalled
//   Sum, cout, ovf       : result, carry-out (borrow-out for subtract), signed overflow
// Stage 1 runs the lower half of the prefix levels, stage 2 the rest plus the sum.
module sklansky_addsub_pipe
    import sklansky_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned Levels   = $clog2(WIDTH);
    localparam int unsigned S1Levels = Levels / 2;
    localparam int unsigned S2Levels = Levels - S1Levels;

    // ---------------------------------------------------------------- stage 1 logic
    logic [WIDTH-1:0]  bx;
    logic [WIDTH-1:0]  p_raw;
    logic              c0;
    pg_t [WIDTH-1:0]   pg0;
    pg_t [WIDTH-1:0]   s1_tree;

    assign bx    = (op == OP_SUB) ? ~B : B;
    assign c0    = (op == OP_SUB) ? ~cin : cin;
    assign p_raw = A ^ bx;

    // The carry-in is merged into bit 0 so the tree only spans WIDTH positions; bit 0
    // then carries the group generate of {bit 0, carry-in} and no propagate.
    always_comb begin
        for (int i = 0; i < int'(WIDTH); i++) begin
            pg0[i].g = A[i] & bx[i];
            pg0[i].p = p_raw[i];
        end
        pg0[0].g = (A[0] & bx[0]) | (p_raw[0] & c0);
        pg0[0].p = 1'b0;
    end

    for (genvar k = 0; k < int'(S1Levels); k++) begin : g_s1_lvl
        pg_t [WIDTH-1:0] prv;
        pg_t [WIDTH-1:0] nxt;
        if (k == 0) begin : g_first
            assign prv = pg0;
        end else begin : g_chain
            assign prv = g_s1_lvl[k-1].nxt;
        end
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            if (((i >> k) & 1) == 1) begin : g_cell
                localparam int unsigned Lo = sklansky_partner(i, k);
                sklansky_black_cell u_cell (
                    .hi_i  (prv[i]),
                    .lo_i  (prv[Lo]),
                    .res_o (nxt[i])
                );
            end else begin : g_pass
                assign nxt[i] = prv[i];
            end
        end
    end

    assign s1_tree = g_s1_lvl[S1Levels-1].nxt;

    // ---------------------------------------------------------------- stage 1 registers
    logic             s1_v_q;
    pg_t [WIDTH-1:0]  s1_pg_q;
    logic [WIDTH-1:0] s1_p_q;
    logic             s1_c0_q;
    logic             s1_op_q;
    logic             s1_amsb_q;
    logic             s1_bxmsb_q;

    logic s1_ready;
    logic s2_ready;
    logic s1_load;
    logic s2_load;

    // Combinational ready chain: a full stage can take new data if it empties this cycle.
    assign s2_ready = ~out_valid | out_ready;
    assign s1_ready = ~s1_v_q | s2_ready;
    assign in_ready = s1_ready;
    assign s1_load  = in_valid & s1_ready;
    assign s2_load  = s1_v_q & s2_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_pg_q    <= '0;
            s1_p_q     <= '0;
            s1_c0_q    <= 1'b0;
            s1_op_q    <= 1'b0;
            s1_amsb_q  <= 1'b0;
            s1_bxmsb_q <= 1'b0;
        end else begin
            if (s1_ready) begin
                s1_v_q <= in_valid;
            end
            if (s1_load) begin
                s1_pg_q    <= s1_tree;
                s1_p_q     <= p_raw;
                s1_c0_q    <= c0;
                s1_op_q    <= op;
                s1_amsb_q  <= A[WIDTH-1];
                s1_bxmsb_q <= bx[WIDTH-1];
            end
        end
    end

    // ---------------------------------------------------------------- stage 2 logic
    pg_t [WIDTH-1:0]  s2_tree;
    logic [WIDTH-1:0] gfin;
    logic [WIDTH-1:0] sum_d;
    logic             carry;
    logic             cout_d;
    logic             ovf_d;

    for (genvar j = 0; j < int'(S2Levels); j++) begin : g_s2_lvl
        localparam int unsigned K = S1Levels + j;
        pg_t [WIDTH-1:0] prv;
        pg_t [WIDTH-1:0] nxt;
        if (j == 0) begin : g_first
            assign prv = s1_pg_q;
        end else begin : g_chain
            assign prv = g_s2_lvl[j-1].nxt;
        end
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
            if (((i >> K) & 1) == 1) begin : g_cell
                localparam int unsigned Lo = sklansky_partner(i, K);
                sklansky_black_cell u_cell (
                    .hi_i  (prv[i]),
                    .lo_i  (prv[Lo]),
                    .res_o (nxt[i])
                );
            end else begin : g_pass
                assign nxt[i] = prv[i];
            end
        end
    end

    assign s2_tree = g_s2_lvl[S2Levels-1].nxt;

    // Group propagates are not needed once the tree is complete.
    logic unused_fin_p;
    always_comb begin
        gfin         = '0;
        unused_fin_p = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            gfin[i]      = s2_tree[i].g;
            unused_fin_p = unused_fin_p ^ s2_tree[i].p;
        end
    end

    // Carry into bit i is the group generate of bits i-1..0 (carry-in already folded).
    assign sum_d  = s1_p_q ^ {gfin[WIDTH-2:0], s1_c0_q};
    assign carry  = gfin[WIDTH-1];
    assign cout_d = (s1_op_q == OP_SUB) ? ~carry : carry;
    assign ovf_d  = (s1_amsb_q == s1_bxmsb_q) && (sum_d[WIDTH-1] != s1_amsb_q);

    // ---------------------------------------------------------------- output registers
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            if (s2_ready) begin
                out_valid_q <= s1_v_q;
            end
            if (s2_load) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_sklansky_addsub_pipe.sv
// Self-checking bench for sklansky_addsub_pipe: directed vector table, backpressure,
// full-throughput streaming and mid-flight reset sequences.
module tb_sklansky_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        op = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    sklansky_addsub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .A         (a),
        .B         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int   total = 0;
    int   bad = 0;
    int   rx_cnt = 0;
    bit   mon_en = 1'b0;
    res_t exp_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference: plain 17-bit arithmetic, subtract as a true difference.
    function automatic res_t model(logic o, logic [15:0] x, logic [15:0] y, logic c);
        logic [16:0] t;
        logic [15:0] yx;
        res_t        r;
        if (o == 1'b0) begin
            t  = {1'b0, x} + {1'b0, y} + {16'd0, c};
            yx = y;
        end else begin
            t  = {1'b0, x} - {1'b0, y} - {16'd0, c};
            yx = ~y;
        end
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (x[15] == yx[15]) && (r.sum[15] != x[15]);
        return r;
    endfunction

    task automatic drive(logic o, logic [15:0] x, logic [15:0] y, logic c);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
        cin      = c;
    endtask

    // Stream monitor: every result transferred must match the next expected entry.
    always @(negedge clk) begin : monitor
        res_t e;
        if (mon_en && rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum %0h want none", sum);
            end else begin
                e = exp_q.pop_front();
                chk("stream_sum", {16'd0, sum}, {16'd0, e.sum});
                chk("stream_cout", {31'd0, cout}, {31'd0, e.cout});
                chk("stream_ovf", {31'd0, ovf}, {31'd0, e.ovf});
            end
            rx_cnt++;
        end
    end

    initial begin
        vec_t        v[12];
        int          rx0;
        res_t        r;
        logic        ro;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        v[0]  = '{1'b0, 16'd345,  16'd134,  1'b0, 16'd479,  1'b0, 1'b0};
        v[1]  = '{1'b1, 16'd4567, 16'd234,  1'b0, 16'd4333, 1'b0, 1'b0};
        v[2]  = '{1'b1, 16'd23,   16'd10,   1'b1, 16'd12,   1'b0, 1'b0};
        v[3]  = '{1'b1, 16'd0,    16'd1,    1'b0, 16'hFFFF, 1'b1, 1'b0};
        v[4]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        v[5]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[6]  = '{1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        v[7]  = '{1'b0, 16'h1234, 16'h0001, 1'b1, 16'h1236, 1'b0, 1'b0};
        v[8]  = '{1'b1, 16'd5,    16'd5,    1'b0, 16'h0000, 1'b0, 1'b0};
        v[9]  = '{1'b1, 16'd5,    16'd5,    1'b1, 16'hFFFF, 1'b1, 1'b0};
        v[10] = '{1'b0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        v[11] = '{1'b1, 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};

        // Reset state
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", {16'd0, sum}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, one beat at a time with a latency check
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #2 drive(v[i].op, v[i].a, v[i].b, v[i].cin);
            @(negedge clk);
            chk("tbl_in_ready", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #2 in_valid = 1'b0;
            @(negedge clk);
            chk("tbl_latency_early", {31'd0, out_valid}, 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk("tbl_out_valid", {31'd0, out_valid}, 32'd1);
            chk("tbl_sum", {16'd0, sum}, {16'd0, v[i].sum});
            chk("tbl_cout", {31'd0, cout}, {31'd0, v[i].cout});
            chk("tbl_ovf", {31'd0, ovf}, {31'd0, v[i].ovf});
        end
        @(posedge clk);
        @(posedge clk);
        #2 mon_en = 1'b1;

        // Backpressure: fill both stages, stall, then release
        rx0 = rx_cnt;
        @(posedge clk);
        #2 out_ready = 1'b0;
        drive(1'b0, 16'd100, 16'd200, 1'b0);
        exp_q.push_back(model(1'b0, 16'd100, 16'd200, 1'b0));
        @(negedge clk);
        chk("bp_in_ready_b0", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2 drive(1'b1, 16'd1000, 16'd1, 1'b0);
        exp_q.push_back(model(1'b1, 16'd1000, 16'd1, 1'b0));
        @(negedge clk);
        chk("bp_in_ready_b1", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2 drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        @(negedge clk);
        chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_sum_first", {16'd0, sum}, 32'd300);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_stall_sum", {16'd0, sum}, 32'd300);
            chk("bp_stall_cout", {31'd0, cout}, 32'd0);
        end
        @(posedge clk);
        #2 out_ready = 1'b1;
        exp_q.push_back(model(1'b0, 16'hFFFF, 16'hFFFF, 1'b1));
        #1 chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2 drive(1'b1, 16'd3, 16'd4, 1'b0);
        exp_q.push_back(model(1'b1, 16'd3, 16'd4, 1'b0));
        @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_rx_count", rx_cnt - rx0, 32'd4);
        chk("bp_queue_empty", exp_q.size(), 32'd0);

        // Full throughput: 16 back-to-back beats
        rx0 = rx_cnt;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            ro = 1'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            #2 drive(ro, ra, rb, rc);
            r = model(ro, ra, rb, rc);
            exp_q.push_back(r);
            @(negedge clk);
            chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
        end
        @(posedge clk);
        #2 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 chk("tp_consecutive_rx", rx_cnt - rx0, 32'd16);
        chk("tp_queue_empty", exp_q.size(), 32'd0);

        // Reset with both stages full: in-flight beats must vanish
        @(posedge clk);
        #2 out_ready = 1'b0;
        drive(1'b0, 16'd1, 16'd2, 1'b0);
        @(posedge clk);
        #2 drive(1'b0, 16'd3, 16'd4, 1'b0);
        @(posedge clk);
        #2 in_valid = 1'b0;
        @(negedge clk);
        chk("mid_full_out_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_sum", {16'd0, sum}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_cout", {31'd0, cout}, 32'd0);
        rx0 = rx_cnt;
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 16'd6409, 16'd0, 1'b0);
        exp_q.push_back(model(1'b0, 16'd6409, 16'd0, 1'b0));
        @(posedge clk);
        #2 in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_latency_early", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd1);
        chk("post_rst_sum", {16'd0, sum}, 32'd6409);
        repeat (3) @(posedge clk);
        #1 chk("post_rst_rx_count", rx_cnt - rx0, 32'd1);
        chk("post_rst_queue_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
